mem_write_checker: RTL and testbench

Synthesizable end-of-test checker for the pipelined processor's simulation and FPGA bring-up. It watches the data-memory write port (MemWriteM/DataAdrM/WriteDataM) and compares stores in order against a programmable table of expected (address, data) pairs. It also applies a cycle-budget timeout and reports pass, fail or timeout as registered status, replacing hard-coded store checks and timeouts in individual benches.

---
 rtl/mem_write_checker.sv | 172 +++++++++++++++++
 tb/tb_mem_write_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks data-memory stores in order against a table of
// expected (addr, data) pairs, with a cycle budget and a registered verdict.
// Ports: clk, reset (async, active-low); exp_we/exp_idx/exp_addr/exp_data
// program the table; start begins a run; mem_write/mem_addr/mem_wdata is the
// monitored store port; busy/done/pass/fail_code/match_count/cycle_count/
// fail_addr/fail_data report status.
module mem_write_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int STRICT         = 0,
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exp_we,
    input  logic [IDX_W-1:0]      exp_idx,
    input  logic [ADDR_WIDTH-1:0] exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  start,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_code,
    output logic [IDX_W:0]        match_count,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam int             TBL_D   = 1 << IDX_W;
    localparam logic [IDX_W:0] NC_W    = (IDX_W + 1)'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

    state_t state_q, state_d;

    logic [IDX_W:0]        match_q, match_d;
    logic [CNT_W-1:0]      cyc_q, cyc_d;
    logic [1:0]            fcode_q, fcode_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;

    // Expected table deliberately has no reset so it survives a mid-run
    // reset and can be reused by the next start without reprogramming.
    logic [ADDR_WIDTH-1:0] tbl_addr_q [TBL_D];
    logic [DATA_WIDTH-1:0] tbl_data_q [TBL_D];

    logic             tbl_we;
    logic [IDX_W-1:0] cmp_idx;
    logic             hit;
    logic [IDX_W:0]   match_inc;

    assign tbl_we = exp_we && (state_q != S_RUN) && ({1'b0, exp_idx} < NC_W);

    // In RUN match_q is always below NUM_CHECKS, so the low bits suffice.
    assign cmp_idx   = match_q[IDX_W-1:0];
    assign hit       = (mem_addr == tbl_addr_q[cmp_idx]) &&
                       (mem_wdata == tbl_data_q[cmp_idx]);
    assign match_inc = match_q + (IDX_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_addr_q[exp_idx] <= exp_addr;
            tbl_data_q[exp_idx] <= exp_data;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        cyc_d   = cyc_q;
        fcode_d = fcode_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;

        unique case (state_q)
            S_RUN: begin
                if (cyc_q != TO_MAX) begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
                if (mem_write) begin
                    if (hit) begin
                        match_d = match_inc;
                        if (match_inc == NC_W) begin
                            state_d = S_PASS;
                        end
                    end else if (STRICT != 0) begin
                        faddr_d = mem_addr;
                        fdata_d = mem_wdata;
                        fcode_d = FC_MISMATCH;
                        state_d = S_FAIL;
                    end
                end
                // Timeout only if this cycle did not already decide the run.
                if (state_d == S_RUN && cyc_q == TO_LAST) begin
                    fcode_d = FC_TIMEOUT;
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    match_d = '0;
                    cyc_d   = '0;
                    fcode_d = FC_NONE;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_PASS) || (state_d == S_FAIL) ||
                 (state_d == S_TIMEOUT);
        pass_d = (state_d == S_PASS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            match_q <= '0;
            cyc_q   <= '0;
            fcode_q <= '0;
            faddr_q <= '0;
            fdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            cyc_q   <= cyc_d;
            fcode_q <= fcode_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fcode_q;
    assign match_count = match_q;
    assign cycle_count = cyc_q;
    assign fail_addr   = faddr_q;
    assign fail_data   = fdata_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: two checkers (strict and lenient) share one stimulus
// stream; vector table with scoreboard queue plus multi-cycle sequences.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        exp_we;
    logic [0:0]  exp_idx;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        start;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic        s_busy, s_done, s_pass;
    logic [1:0]  s_fc;
    logic [1:0]  s_mc;
    logic [4:0]  s_cc;
    logic [31:0] s_fa, s_fd;

    logic        l_busy, l_done, l_pass;
    logic [1:0]  l_fc;
    logic [1:0]  l_mc;
    logic [4:0]  l_cc;
    logic [31:0] l_fa, l_fd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_write_checker #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CHECKS(2),
        .TIMEOUT_CYCLES(20), .STRICT(1)
    ) u_strict (
        .clk(clk), .reset(reset),
        .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .start(start), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .fail_code(s_fc), .match_count(s_mc), .cycle_count(s_cc),
        .fail_addr(s_fa), .fail_data(s_fd)
    );

    mem_write_checker #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CHECKS(2),
        .TIMEOUT_CYCLES(20), .STRICT(0)
    ) u_len (
        .clk(clk), .reset(reset),
        .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .start(start), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(l_busy), .done(l_done), .pass(l_pass),
        .fail_code(l_fc), .match_count(l_mc), .cycle_count(l_cc),
        .fail_addr(l_fa), .fail_data(l_fd)
    );

    typedef struct {
        logic        mw;
        logic [31:0] a;
        logic [31:0] d;
        logic        s_busy, s_done, s_pass;
        logic [1:0]  s_fc;
        logic [1:0]  s_mc;
        logic [4:0]  s_cc;
        logic        l_busy, l_done, l_pass;
        logic [1:0]  l_fc;
        logic [1:0]  l_mc;
        logic [4:0]  l_cc;
    } vec_t;

    vec_t vecs[5];
    vec_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_busy"}, 64'(s_busy), 64'd0);
        chk({tag, "_s_done"}, 64'(s_done), 64'd0);
        chk({tag, "_s_pass"}, 64'(s_pass), 64'd0);
        chk({tag, "_s_fc"}, 64'(s_fc), 64'd0);
        chk({tag, "_s_mc"}, 64'(s_mc), 64'd0);
        chk({tag, "_s_cc"}, 64'(s_cc), 64'd0);
        chk({tag, "_s_fa"}, 64'(s_fa), 64'd0);
        chk({tag, "_s_fd"}, 64'(s_fd), 64'd0);
        chk({tag, "_l_busy"}, 64'(l_busy), 64'd0);
        chk({tag, "_l_mc"}, 64'(l_mc), 64'd0);
        chk({tag, "_l_cc"}, 64'(l_cc), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   g;

        //          mw   addr     data    s: busy done pass fc mc cc    l: busy done pass fc mc cc
        vecs[0] = '{1'b1, 32'h60, 32'h3, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1,
                    1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 5'd1};
        vecs[1] = '{1'b0, 32'h64, 32'h7, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1,
                    1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 5'd2};
        vecs[2] = '{1'b1, 32'h64, 32'h7, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1,
                    1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 5'd3};
        vecs[3] = '{1'b1, 32'h68, 32'h9, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1,
                    1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 5'd4};
        vecs[4] = '{1'b1, 32'h64, 32'h7, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1,
                    1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 5'd4};

        reset     = 1'b0;
        exp_we    = 1'b0;
        exp_idx   = '0;
        exp_addr  = '0;
        exp_data  = '0;
        start     = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tick();
        tick();
        chk_zero("rst");

        reset = 1'b1;
        exp_we = 1'b1;
        exp_idx = 1'b0; exp_addr = 32'h64; exp_data = 32'h7;
        tick();
        exp_idx = 1'b1; exp_addr = 32'h68; exp_data = 32'h9;
        tick();
        exp_we = 1'b0;

        do_start();
        chk("start_s_busy", 64'(s_busy), 64'd1);
        chk("start_l_busy", 64'(l_busy), 64'd1);
        chk("start_s_cc", 64'(s_cc), 64'd0);

        // Vector table: strict fails on the first wrong store, lenient skips it.
        for (int i = 0; i < 5; i++) begin
            mem_write = vecs[i].mw;
            mem_addr  = vecs[i].a;
            mem_wdata = vecs[i].d;
            sb.push_back(vecs[i]);
            tick();
            mem_write = 1'b0;
            e = sb.pop_front();
            chk($sformatf("v%0d_s_busy", i), 64'(s_busy), 64'(e.s_busy));
            chk($sformatf("v%0d_s_done", i), 64'(s_done), 64'(e.s_done));
            chk($sformatf("v%0d_s_pass", i), 64'(s_pass), 64'(e.s_pass));
            chk($sformatf("v%0d_s_fc", i), 64'(s_fc), 64'(e.s_fc));
            chk($sformatf("v%0d_s_mc", i), 64'(s_mc), 64'(e.s_mc));
            chk($sformatf("v%0d_s_cc", i), 64'(s_cc), 64'(e.s_cc));
            chk($sformatf("v%0d_l_busy", i), 64'(l_busy), 64'(e.l_busy));
            chk($sformatf("v%0d_l_done", i), 64'(l_done), 64'(e.l_done));
            chk($sformatf("v%0d_l_pass", i), 64'(l_pass), 64'(e.l_pass));
            chk($sformatf("v%0d_l_fc", i), 64'(l_fc), 64'(e.l_fc));
            chk($sformatf("v%0d_l_mc", i), 64'(l_mc), 64'(e.l_mc));
            chk($sformatf("v%0d_l_cc", i), 64'(l_cc), 64'(e.l_cc));
        end
        chk("strict_fail_addr", 64'(s_fa), 64'h60);
        chk("strict_fail_data", 64'(s_fd), 64'h3);
        chk("len_fail_addr", 64'(l_fa), 64'h0);

        // Timeout: no stores, done lands on the 20th RUN cycle.
        do_start();
        chk("to_start_s_fa", 64'(s_fa), 64'h0);
        chk("to_start_s_fc", 64'(s_fc), 64'd0);
        chk("to_start_s_busy", 64'(s_busy), 64'd1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 19) begin
                chk("to_19_done", 64'(s_done), 64'd0);
                chk("to_19_cc", 64'(s_cc), 64'd19);
            end
        end
        chk("to_s_done", 64'(s_done), 64'd1);
        chk("to_s_fc", 64'(s_fc), 64'd2);
        chk("to_s_busy", 64'(s_busy), 64'd0);
        chk("to_s_cc", 64'(s_cc), 64'd20);
        chk("to_l_fc", 64'(l_fc), 64'd2);
        chk("to_l_pass", 64'(l_pass), 64'd0);
        store(32'h64, 32'h7);
        tick();
        tick();
        chk("to_hold_cc", 64'(l_cc), 64'd20);
        chk("to_hold_mc", 64'(l_mc), 64'd0);

        // Boundary: store with start is ignored; final match on last budget cycle.
        mem_write = 1'b1; mem_addr = 32'h64; mem_wdata = 32'h7;
        do_start();
        mem_write = 1'b0;
        chk("bnd_startstore_l_mc", 64'(l_mc), 64'd0);
        chk("bnd_startstore_s_mc", 64'(s_mc), 64'd0);
        store(32'h64, 32'h7);
        chk("bnd_first_mc", 64'(s_mc), 64'd1);
        g = 0;
        while (l_cc != 5'd19 && g < 40) begin
            tick();
            g++;
        end
        chk("bnd_reach_cc", 64'(l_cc), 64'd19);
        store(32'h68, 32'h9);
        chk("bnd_s_pass", 64'(s_pass), 64'd1);
        chk("bnd_s_fc", 64'(s_fc), 64'd0);
        chk("bnd_s_done", 64'(s_done), 64'd1);
        chk("bnd_l_pass", 64'(l_pass), 64'd1);
        chk("bnd_s_cc", 64'(s_cc), 64'd20);

        // Asynchronous reset mid-run.
        do_start();
        store(32'h64, 32'h7);
        chk("mid_mc", 64'(s_mc), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        reset = 1'b1;

        // Restart on preserved table; RUN-time table write must be ignored.
        do_start();
        exp_we = 1'b1; exp_idx = 1'b0; exp_addr = 32'h64; exp_data = 32'hdead;
        tick();
        exp_we = 1'b0;
        store(32'h64, 32'h7);
        chk("rs_l_mc1", 64'(l_mc), 64'd1);
        chk("rs_s_busy", 64'(s_busy), 64'd1);
        store(32'h68, 32'h9);
        chk("rs_s_pass", 64'(s_pass), 64'd1);
        chk("rs_s_mc2", 64'(s_mc), 64'd2);
        chk("rs_l_pass", 64'(l_pass), 64'd1);

        // Table write and start in the same cycle: the run uses the new entry.
        exp_we = 1'b1; exp_idx = 1'b1; exp_addr = 32'h70; exp_data = 32'h5;
        do_start();
        exp_we = 1'b0;
        store(32'h64, 32'h7);
        store(32'h70, 32'h5);
        chk("ws_s_pass", 64'(s_pass), 64'd1);
        chk("ws_s_fc", 64'(s_fc), 64'd0);
        chk("ws_l_mc", 64'(l_mc), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
